// File: rtl/dec_10b8b.sv
// 10b/8b symbol decoder with running-disparity tracking and comma-based
// link synchronisation. One symbol is accepted per cycle with in_valid;
// all outputs are registered and appear on the following cycle.
module dec_10b8b #(
    parameter int SYNC_COMMAS = 3,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [9:0] din,
    output logic       out_valid,
    output logic [7:0] dout,
    output logic       kout,
    output logic       code_err,
    output logic       disp_err,
    output logic       comma_det,
    output logic       rd_out,
    output logic       sync
);

    localparam int CW = (SYNC_COMMAS > 1) ? $clog2(SYNC_COMMAS + 1) : 1;
    localparam int EW = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;
    localparam int GW = (GOOD_RUN > 1) ? $clog2(GOOD_RUN + 1) : 1;

    // The sync output is the FSM state register itself (ST_SYNC <=> sync=1).
    typedef enum logic {
        ST_LOS  = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

    // Handshake: a symbol is consumed on every rising edge where in_valid=1;
    // out_valid is high for exactly the next cycle and marks fresh outputs.
    // There is no backpressure: the decoder always accepts.

    state_t         state, state_nx;
    logic [CW-1:0]  comma_cnt, comma_cnt_nx;
    logic [EW-1:0]  err_cnt, err_cnt_nx;
    logic [GW-1:0]  good_cnt, good_cnt_nx;
    logic           rd_q;

    logic [5:0]     s6;
    logic [3:0]     s4;
    logic [3:0]     s4k;
    logic [4:0]     x6;
    logic [2:0]     y4, yk, y_c;
    logic           v6, v4, vk, alt4;
    logic           k28, k28_pos, alt_ok, alt_k;
    logic [2:0]     w6, w4;
    logic           rd6, rd4, de6, de4;
    logic           code_err_c, disp_err_c, kout_c, comma_c, err_c;
    logic [7:0]     dout_c;

    assign s6      = din[9:4];
    assign s4      = din[3:0];
    assign k28     = (s6 == 6'b001111) || (s6 == 6'b110000);
    assign k28_pos = (s6 == 6'b110000);
    // The RD+ flavour of every K28 symbol is the bitwise complement of the
    // RD- flavour, so fold it back before looking up the K28 4b code.
    assign s4k     = k28_pos ? ~s4 : s4;
    assign w6      = 3'($countones(s6));
    assign w4      = 3'($countones(s4));

    // 6b sub-block lookup: both RD forms of every data code plus K28.
    always_comb begin
        x6 = 5'd0;
        v6 = 1'b1;
        case (s6)
            6'b100111, 6'b011000: x6 = 5'd0;
            6'b011101, 6'b100010: x6 = 5'd1;
            6'b101101, 6'b010010: x6 = 5'd2;
            6'b110001:            x6 = 5'd3;
            6'b110101, 6'b001010: x6 = 5'd4;
            6'b101001:            x6 = 5'd5;
            6'b011001:            x6 = 5'd6;
            6'b111000, 6'b000111: x6 = 5'd7;
            6'b111001, 6'b000110: x6 = 5'd8;
            6'b100101:            x6 = 5'd9;
            6'b010101:            x6 = 5'd10;
            6'b110100:            x6 = 5'd11;
            6'b001101:            x6 = 5'd12;
            6'b101100:            x6 = 5'd13;
            6'b011100:            x6 = 5'd14;
            6'b010111, 6'b101000: x6 = 5'd15;
            6'b011011, 6'b100100: x6 = 5'd16;
            6'b100011:            x6 = 5'd17;
            6'b010011:            x6 = 5'd18;
            6'b110010:            x6 = 5'd19;
            6'b001011:            x6 = 5'd20;
            6'b101010:            x6 = 5'd21;
            6'b011010:            x6 = 5'd22;
            6'b111010, 6'b000101: x6 = 5'd23;
            6'b110011, 6'b001100: x6 = 5'd24;
            6'b100110:            x6 = 5'd25;
            6'b010110:            x6 = 5'd26;
            6'b110110, 6'b001001: x6 = 5'd27;
            6'b001110:            x6 = 5'd28;
            6'b001111, 6'b110000: x6 = 5'd28;
            6'b101110, 6'b010001: x6 = 5'd29;
            6'b011110, 6'b100001: x6 = 5'd30;
            6'b101011, 6'b010100: x6 = 5'd31;
            default:              v6 = 1'b0;
        endcase
    end

    // 4b sub-block lookup for data symbols, flagging the alternate D.x.A7 form.
    always_comb begin
        y4   = 3'd0;
        v4   = 1'b1;
        alt4 = 1'b0;
        case (s4)
            4'b0100, 4'b1011: y4 = 3'd0;
            4'b1001:          y4 = 3'd1;
            4'b0101:          y4 = 3'd2;
            4'b0011, 4'b1100: y4 = 3'd3;
            4'b0010, 4'b1101: y4 = 3'd4;
            4'b1010:          y4 = 3'd5;
            4'b0110:          y4 = 3'd6;
            4'b0001, 4'b1110: y4 = 3'd7;
            4'b0111, 4'b1000: begin
                y4   = 3'd7;
                alt4 = 1'b1;
            end
            default:          v4 = 1'b0;
        endcase
    end

    // 4b lookup for K28 symbols (after folding), RD- flavour only.
    always_comb begin
        yk = 3'd0;
        vk = 1'b1;
        case (s4k)
            4'b0100: yk = 3'd0;
            4'b1001: yk = 3'd1;
            4'b0101: yk = 3'd2;
            4'b0011: yk = 3'd3;
            4'b0010: yk = 3'd4;
            4'b1010: yk = 3'd5;
            4'b0110: yk = 3'd6;
            4'b1000: yk = 3'd7;
            default: vk = 1'b0;
        endcase
    end

    assign alt_ok = x6 inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20,
                               5'd23, 5'd27, 5'd29, 5'd30};
    assign alt_k  = x6 inside {5'd23, 5'd27, 5'd29, 5'd30};

    assign code_err_c = !v6 || (k28 ? !vk : (!v4 || (alt4 && !alt_ok)));
    assign y_c        = k28 ? yk : y4;
    assign kout_c     = !code_err_c && (k28 || (alt4 && alt_k));
    assign dout_c     = code_err_c ? 8'h00 : {y_c, x6};
    assign comma_c    = !code_err_c && k28 &&
                        ((y_c == 3'd1) || (y_c == 3'd5) || (y_c == 3'd7));

    // Running disparity through the 6b then the 4b sub-block, from raw bits.
    always_comb begin
        rd6 = rd_q;
        if (w6 > 3'd3)              rd6 = 1'b1;
        else if (w6 < 3'd3)         rd6 = 1'b0;
        else if (s6 == 6'b000111)   rd6 = 1'b1;
        else if (s6 == 6'b111000)   rd6 = 1'b0;
        rd4 = rd6;
        if (w4 > 3'd2)              rd4 = 1'b1;
        else if (w4 < 3'd2)         rd4 = 1'b0;
        else if (s4 == 4'b0011)     rd4 = 1'b1;
        else if (s4 == 4'b1100)     rd4 = 1'b0;
    end

    assign de6 = ((w6 == 3'd4) && rd_q) || ((w6 == 3'd2) && !rd_q) ||
                 ((s6 == 6'b000111) && !rd_q) || ((s6 == 6'b111000) && rd_q);
    assign de4 = ((w4 == 3'd3) && rd6) || ((w4 == 3'd1) && !rd6) ||
                 ((s4 == 4'b0011) && !rd6) || ((s4 == 4'b1100) && rd6);
    assign disp_err_c = de6 || de4;
    assign err_c      = code_err_c || disp_err_c;

    // Sync FSM next state and counters, assuming the current symbol is accepted.
    always_comb begin
        state_nx     = state;
        comma_cnt_nx = comma_cnt;
        err_cnt_nx   = err_cnt;
        good_cnt_nx  = good_cnt;
        case (state)
            ST_LOS: begin
                if (err_c) begin
                    comma_cnt_nx = '0;
                end else if (comma_c) begin
                    if (comma_cnt >= CW'(SYNC_COMMAS - 1)) begin
                        state_nx     = ST_SYNC;
                        comma_cnt_nx = '0;
                        err_cnt_nx   = '0;
                        good_cnt_nx  = '0;
                    end else begin
                        comma_cnt_nx = comma_cnt + 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (err_c) begin
                    good_cnt_nx = '0;
                    if (err_cnt >= EW'(ERR_LIMIT - 1)) begin
                        state_nx     = ST_LOS;
                        comma_cnt_nx = '0;
                        err_cnt_nx   = '0;
                    end else begin
                        err_cnt_nx = err_cnt + 1'b1;
                    end
                end else if (good_cnt >= GW'(GOOD_RUN - 1)) begin
                    err_cnt_nx  = '0;
                    good_cnt_nx = '0;
                end else begin
                    good_cnt_nx = good_cnt + 1'b1;
                end
            end
            default: state_nx = ST_LOS;
        endcase
    end

    // State, RD and output registers; everything holds while in_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= 8'h00;
            kout      <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            comma_det <= 1'b0;
            rd_q      <= 1'b0;
            state     <= ST_LOS;
            comma_cnt <= '0;
            err_cnt   <= '0;
            good_cnt  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout      <= dout_c;
                kout      <= kout_c;
                code_err  <= code_err_c;
                disp_err  <= disp_err_c;
                comma_det <= comma_c;
                rd_q      <= rd4;
                state     <= state_nx;
                comma_cnt <= comma_cnt_nx;
                err_cnt   <= err_cnt_nx;
                good_cnt  <= good_cnt_nx;
            end
        end
    end

    assign rd_out = rd_q;
    assign sync   = (state == ST_SYNC);

endmodule

// File: tb/tb_dec_10b8b.sv
// Directed + random bench for dec_10b8b with a table-driven reference model.
module tb_dec_10b8b;

    localparam int SYNC_COMMAS = 3;
    localparam int ERR_LIMIT   = 4;
    localparam int GOOD_RUN    = 16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [9:0] din;
    logic       out_valid;
    logic [7:0] dout;
    logic       kout, code_err, disp_err, comma_det, rd_out, sync;

    dec_10b8b #(
        .SYNC_COMMAS(SYNC_COMMAS),
        .ERR_LIMIT  (ERR_LIMIT),
        .GOOD_RUN   (GOOD_RUN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .din      (din),
        .out_valid(out_valid),
        .dout     (dout),
        .kout     (kout),
        .code_err (code_err),
        .disp_err (disp_err),
        .comma_det(comma_det),
        .rd_out   (rd_out),
        .sync     (sync)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: {dout, kout, code_err, disp_err, comma_det, rd_out, sync}
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;
    int          n_vec;
    int          n_err;

    // Reference tables (RD- forms; RD+ forms derived by complement)
    logic [5:0] t6n [32];
    logic [5:0] t6p [32];
    logic [3:0] t4n [8];
    logic [3:0] t4p [8];

    // Reference model state
    logic m_rd;
    logic m_sync;
    int   m_cc, m_ec, m_gc;

    function automatic logic [14:0] obs();
        return {out_valid, dout, kout, code_err, disp_err, comma_det, rd_out, sync};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_rd = 1'b0;
        m_sync = 1'b0;
        m_cc = 0;
        m_ec = 0;
        m_gc = 0;
        exp_q.delete();
        last_exp = '0;
    endtask

    task automatic model_step(input logic [9:0] sym, output logic [13:0] e);
        logic [5:0] s6;
        logic [3:0] s4, kp;
        logic [4:0] x;
        logic [2:0] y;
        logic [7:0] d;
        logic v6, v4, alt, k28, ce, de, cm, ko, err, r;
        int d6, d4;
        s6 = sym[9:4];
        s4 = sym[3:0];
        v6 = 1'b0;
        x = 5'd0;
        for (int i = 0; i < 32; i++)
            if (s6 == t6n[i] || s6 == t6p[i]) begin v6 = 1'b1; x = 5'(i); end
        k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
        if (k28) begin v6 = 1'b1; x = 5'd28; end
        v4 = 1'b0; y = 3'd0; alt = 1'b0;
        if (k28) begin
            for (int i = 0; i < 8; i++) begin
                kp = (i == 7) ? 4'b1000 : t4p[i];
                if ((s6 == 6'b001111 && s4 == kp) || (s6 == 6'b110000 && s4 == ~kp)) begin
                    v4 = 1'b1; y = 3'(i);
                end
            end
        end else begin
            for (int i = 0; i < 8; i++)
                if (s4 == t4n[i] || s4 == t4p[i]) begin v4 = 1'b1; y = 3'(i); end
            if (s4 == 4'b0111 || s4 == 4'b1000) begin v4 = 1'b1; alt = 1'b1; y = 3'd7; end
        end
        ce = !v6 || !v4 ||
             (alt && !(x inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20,
                                 5'd23, 5'd27, 5'd29, 5'd30}));
        ko = !ce && (k28 || (alt && (x inside {5'd23, 5'd27, 5'd29, 5'd30})));
        d  = ce ? 8'h00 : {y, x};
        cm = !ce && k28 && (y == 3'd1 || y == 3'd5 || y == 3'd7);
        // disparity of each sub-block in units of ones-minus-zeros
        d6 = int'($countones(s6)) * 2 - 6;
        d4 = int'($countones(s4)) * 2 - 4;
        r  = m_rd;
        de = (d6 == 2 && r) || (d6 == -2 && !r) ||
             (s6 == 6'b000111 && !r) || (s6 == 6'b111000 && r);
        if (d6 > 0) r = 1'b1;
        else if (d6 < 0) r = 1'b0;
        else if (s6 == 6'b000111) r = 1'b1;
        else if (s6 == 6'b111000) r = 1'b0;
        de = de || (d4 == 2 && r) || (d4 == -2 && !r) ||
             (s4 == 4'b0011 && !r) || (s4 == 4'b1100 && r);
        if (d4 > 0) r = 1'b1;
        else if (d4 < 0) r = 1'b0;
        else if (s4 == 4'b0011) r = 1'b1;
        else if (s4 == 4'b1100) r = 1'b0;
        m_rd = r;
        err = ce || de;
        if (!m_sync) begin
            if (err) m_cc = 0;
            else if (cm) begin
                m_cc++;
                if (m_cc >= SYNC_COMMAS) begin m_sync = 1'b1; m_cc = 0; m_ec = 0; m_gc = 0; end
            end
        end else begin
            if (err) begin
                m_ec++;
                m_gc = 0;
                if (m_ec >= ERR_LIMIT) begin m_sync = 1'b0; m_cc = 0; m_ec = 0; m_gc = 0; end
            end else begin
                m_gc++;
                if (m_gc >= GOOD_RUN) begin m_ec = 0; m_gc = 0; end
            end
        end
        e = {d, ko, ce, de, cm, r, m_sync};
    endtask

    // Driver: one accepted symbol, checked on the following falling edge.
    task automatic send(input logic [9:0] sym, input string tag,
                        input bit hard_en, input logic [13:0] hard);
        logic [13:0] e;
        logic [13:0] got;
        model_step(sym, e);
        exp_q.push_back(e);
        in_valid = 1'b1;
        din = sym;
        @(negedge clk);
        in_valid = 1'b0;
        got = exp_q.pop_front();
        last_exp = got;
        check(tag, obs(), {1'b1, got});
        if (hard_en) check({tag, "_const"}, obs(), {1'b1, hard});
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        din = 10'($urandom_range(0, 1023));
        @(negedge clk);
        check(tag, obs(), {1'b0, last_exp});
    endtask

    // Reset: may be called at any falling edge, even with in_valid high.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, obs(), 15'h0000);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] r6;
        logic [3:0] r4;
        logic [4:0] rx;
        n_vec = 0;
        n_err = 0;
        t6n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        for (int i = 0; i < 32; i++)
            t6p[i] = ($countones(t6n[i]) != 3 || i == 7) ? ~t6n[i] : t6n[i];
        t4n = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        for (int i = 0; i < 8; i++)
            t4p[i] = ($countones(t4n[i]) != 2 || i == 3) ? ~t4n[i] : t4n[i];

        rst_n = 1'b1;
        in_valid = 1'b0;
        din = 10'h000;
        model_reset();
        @(negedge clk);
        do_reset("reset_initial");

        // K28.5 RD-
        send(10'h0FA, "k28_5", 1, {8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

        // D0.0 then D21.5 from RD-
        do_reset("reset_b");
        send(10'h274, "d0_0", 1, {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        send(10'h2AA, "d21_5", 1, {8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // code error, then wrong-polarity D0.0
        do_reset("reset_c");
        send(10'h000, "all_zero", 1, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        send(10'h18B, "d0_0_rdp", 1, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});

        // alternate 4b legality and K28 polarity pairing
        do_reset("reset_d");
        send(10'h237, "d17_a7", 1, {8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        send(10'h187, "alt_bad", 1, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        send(10'h304, "k28_badpol", 1, {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        send(10'h3A8, "k23_7", 1, {8'hF7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // comma sync with an interrupting error
        do_reset("reset_e");
        send(10'h0FA, "comma1", 0, '0);
        send(10'h305, "comma2", 0, '0);
        send(10'h000, "comma_break", 0, '0);
        send(10'h0FA, "comma1b", 0, '0);
        send(10'h305, "comma2b", 1, {8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        send(10'h0FA, "comma3b", 1, {8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});

        // errors too close together drop sync on the fourth
        send(10'h0FA, "err1", 1, {8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        repeat (3) send(10'h2AA, "clean", 0, '0);
        send(10'h0FA, "err2", 0, '0);
        repeat (5) send(10'h2AA, "clean", 0, '0);
        send(10'h0FA, "err3", 0, '0);
        repeat (GOOD_RUN - 1) send(10'h2AA, "clean", 0, '0);
        send(10'h0FA, "err4_los", 1, {8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});

        // resync, then errors spaced by a full good run keep sync
        send(10'h305, "resync1", 0, '0);
        send(10'h0FA, "resync2", 0, '0);
        send(10'h305, "resync3", 0, '0);
        send(10'h18B, "sp_err1", 0, '0);
        for (int k = 0; k < 3; k++) begin
            repeat (GOOD_RUN) send(10'h2AA, "clean", 0, '0);
            send(10'h0FA, "sp_err", 0, '0);
        end
        check("sync_kept", obs(), {1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});

        // stall: outputs hold, out_valid low
        repeat (5) idle("stall");

        // random symbols from the code space
        for (int k = 0; k < 60; k++) begin
            rx = 5'($urandom_range(0, 31));
            r6 = ($urandom_range(0, 1) == 1) ? t6p[rx] : t6n[rx];
            if ($urandom_range(0, 5) == 0) r6 = ($urandom_range(0, 1) == 1) ? 6'b001111 : 6'b110000;
            r4 = 4'($urandom_range(0, 15));
            send({r6, r4}, "random", 0, '0);
            if ($urandom_range(0, 7) == 0) idle("random_idle");
        end

        // reset in the middle of traffic, then decode from RD-
        send(10'h0FA, "pre_reset", 0, '0);
        in_valid = 1'b1;
        din = 10'h2AA;
        do_reset("reset_mid");
        send(10'h0FA, "post_reset", 1, {8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dec_10b8b.md
Name: dec_10b8b

Overview:
- Receive-side counterpart to the transmit 5b/6b + 3b/4b encoders.
- Decodes one 10b symbol per accepted cycle into an 8b byte plus K flag.
- Tracks running disparity (RD) and flags code and disparity errors.
- Runs a comma-based sync state machine that qualifies the link. Sits between the deserializer/word aligner and the receive datapath.

Parameters:
- SYNC_COMMAS, 3: consecutive clean comma symbols needed to enter SYNC.
- ERR_LIMIT, 4: accumulated errors in SYNC that force LOS.
- GOOD_RUN, 16: consecutive clean symbols that clear the error accumulator.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  din carries a symbol this cycle.
- din  input  10  symbol. din[9:4]=abcdei (6b sub-block, a=MSB), din[3:0]=fghj.
- out_valid  output  1  registered outputs updated this cycle.
- dout  output  8  decoded byte {HGF,EDCBA}. EDCBA is the 5b value 0-31.
- kout  output  1  symbol is a control (K) code.
- code_err  output  1  symbol not in the code table.
- disp_err  output  1  symbol illegal for the current RD.
- comma_det  output  1  symbol is K28.1, K28.5 or K28.7.
- rd_out  output  1  RD after this symbol. 0=RD-, 1=RD+.
- sync  output  1  link synchronized.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, internal RD=0 (RD-), FSM=LOS, all counters 0. Reset asserted mid-stream clears everything immediately. The first symbol after release is decoded against RD-.
- Latency: 1 cycle. Outputs register on the clk edge where in_valid=1. out_valid=1 exactly the following cycle.
- in_valid=0: out_valid=0 next cycle; dout/flags/rd_out/sync hold; no RD, FSM or counter change.
- 6b decode: inverse of the 5b/6b table. Accept both RD polarities of each code plus K28 codes 001111/110000.
- 4b decode:
  - 0100/1011 -> 0
  - 1001 -> 1
  - 0101 -> 2
  - 0011/1100 -> 3
  - 0010/1101 -> 4
  - 1010 -> 5
  - 0110 -> 6
  - 0001/1110/0111/1000 -> 7
- Alternate 0111/1000 is legal only after 6b codes of D11/13/14/17/18/20 (data) or 23/27/29/30 (then kout=1).
- kout=1 for any 6b 001111/110000 (K28.y), or for x in {23,27,29,30} with alternate 4b.
- code_err=1 when any of the following holds:
  - 6b or 4b pattern not in the tables.
  - Sub-block disparity is ±4 or ±6.
  - Alternate 4b follows any other 6b.
  - K28 is paired with a 4b of wrong RD polarity.
- On code_err, dout=8'h00 and kout=0.
- disp_err=1 when either sub-block is illegal for the RD entering it:
  - +2 while RD+, or -2 while RD-.
  - 000111 or 0011 while RD-.
  - 111000 or 1100 while RD+.
- disp_err is independent of code_err; both may assert together.
- RD update, per sub-block (6b then 4b):
  - +2 -> RD+; -2 -> RD-.
  - 000111, 0011 -> RD+; 111000, 1100 -> RD-.
  - Other neutral codes leave RD unchanged.
- RD updates even on error, recomputed from the received bits. rd_out is the value after the 4b sub-block.
- Sync FSM, evaluated per accepted symbol:
  - LOS (sync=0), comma counter:
    - comma_det and no errors -> +1.
    - Clean non-comma -> hold.
    - Any error -> clear.
    - Counter reaches SYNC_COMMAS -> SYNC; counters clear. sync=1 in the same output cycle as the qualifying comma.
  - SYNC (sync=1):
    - Each symbol with code_err or disp_err -> error accumulator +1 (one per symbol) and clean-run counter cleared.
    - Clean symbol -> clean-run counter +1. At GOOD_RUN, accumulator=0 and clean-run counter=0.
    - Accumulator reaches ERR_LIMIT -> LOS; counters clear; sync=0 in that symbol's output cycle.
  - Counters saturate and never wrap.

Test Plan:
- Reset, then din=10'h0FA (K28.5 RD-) -> next cycle dout=8'hBC, kout=1, comma_det=1, rd_out=1, no errors.
- RD- then din=10'h274 (D0.0 RD-) -> dout=8'h00, kout=0, rd_out=0. Then din=10'h2AA (D21.5) -> dout=8'hB5, rd_out unchanged.
- RD- then din=10'h18B (D0.0 RD+ form) -> dout=8'h00, disp_err=1, code_err=0. din=10'h000 -> code_err=1, dout=8'h00, kout=0.
- Alternate 10'h0FA, 10'h305, 10'h0FA -> sync=1 on the third output. Insert 10'h000 before the third -> sync stays 0 and count restarts.
- In SYNC, 4 error symbols separated by fewer than 16 clean symbols -> sync=0 on the 4th error output. 16 clean symbols between errors -> sync stays 1.
- Stall din with in_valid=0 for 5 cycles -> out_valid=0 and outputs hold. rst_n low mid-stream -> all outputs 0 immediately, and the next symbol is decoded with RD-.
